// File: rtl/color_pkg.sv
// Shared colour-select definitions for the RGB LED path.
// Imported by sw_color_select and by the LED block that consumes `sel`.
//   color_sel_t  : 3-bit one-hot colour select (or all-zero for "off")
//   COLOR_*      : the four legal select values
//   is_one_hot() : true when a select value names exactly one colour
package color_pkg;

    typedef logic [2:0] color_sel_t;

    localparam color_sel_t COLOR_R   = 3'b001;
    localparam color_sel_t COLOR_G   = 3'b010;
    localparam color_sel_t COLOR_B   = 3'b100;
    localparam color_sel_t COLOR_OFF = 3'b000;

    function automatic logic is_one_hot(input color_sel_t v);
        return (v == COLOR_R) || (v == COLOR_G) || (v == COLOR_B);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: two-flop synchroniser followed by a
// debouncer that only accepts a new level after it has been seen for
// DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset (clears sync, level and count)
//   sw_async : raw asynchronous switch level
//   sw_db    : debounced, synchronous switch level
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_async,
    output logic sw_db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = sw_async;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // Any cycle where the synchronised level agrees with the accepted
        // level discards the partial count, so only an unbroken run of
        // DEBOUNCE_CYCLES mismatches is accepted.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw_db = db_q;

endmodule

// File: rtl/sw_color_select.sv
// Colour-select conditioning for the RGB LED path. Each slide switch is
// synchronised and debounced independently; the debounced pattern is
// decoded to a one-hot colour select and registered, with a one-cycle
// strobe whenever the registered select changes.
// Build option: define SW_SELECT_STICKY_EN to hold the previous select
// when the debounced pattern is all-zero or multi-hot (otherwise those
// patterns decode to COLOR_OFF).
// Ports:
//   CLK100MHZ : 100 MHz board clock, rising edge
//   reset     : synchronous active-low reset
//   SW[2:0]   : raw asynchronous slide-switch levels
//   sel[2:0]  : registered colour select (001, 010, 100 or 000)
//   changed   : one-cycle pulse on the first cycle of a new sel value
module sw_color_select
    import color_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic [2:0] SW,
    output logic [2:0] sel,
    output logic       changed
);

    color_sel_t db;
    color_sel_t next_sel;
    color_sel_t sel_q, sel_d;
    logic       changed_q, changed_d;

    for (genvar i = 0; i < 3; i++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk     (CLK100MHZ),
            .rst_n   (reset),
            .sw_async(SW[i]),
            .sw_db   (db[i])
        );
    end

    always_comb begin
        next_sel = COLOR_OFF;
        if (is_one_hot(db)) begin
            next_sel = db;
        end else begin
`ifdef SW_SELECT_STICKY_EN
            // Invalid patterns keep the last good colour, so no strobe.
            next_sel = sel_q;
`else
            next_sel = COLOR_OFF;
`endif
        end
        sel_d     = next_sel;
        changed_d = (next_sel != sel_q);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            sel_q     <= COLOR_OFF;
            changed_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            changed_q <= changed_d;
        end
    end

    assign sel     = sel_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sw_color_select.sv
module tb_sw_color_select;

    localparam int D = 4;

    logic       CLK100MHZ = 1'b0;
    logic       reset     = 1'b0;
    logic [2:0] SW        = 3'b000;
    logic [2:0] sel;
    logic       changed;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    sw_color_select #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset    (reset),
        .SW       (SW),
        .sel      (sel),
        .changed  (changed)
    );

    // Reference model: a switch level is accepted once the last D
    // synchronised samples seen by the debouncer all disagree with the
    // currently accepted level. Select/strobe follow one edge later.
    logic [2:0] m_s1, m_s2, m_db, m_sel;
    logic       m_chg;
    bit         hist[3][$];

    task automatic model_step();
        logic [2:0] nsel;
        logic [2:0] ndb;
        bit         all_diff;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_sel = '0; m_chg = 1'b0;
            for (int i = 0; i < 3; i++) hist[i].delete();
        end else begin
            if ($countones(m_db) == 1) nsel = m_db;
            else begin
`ifdef SW_SELECT_STICKY_EN
                nsel = m_sel;
`else
                nsel = 3'b000;
`endif
            end
            m_chg = (nsel != m_sel);
            m_sel = nsel;
            ndb = m_db;
            for (int i = 0; i < 3; i++) begin
                hist[i].push_back(m_s2[i]);
                if (hist[i].size() > D) void'(hist[i].pop_front());
                all_diff = (hist[i].size() == D);
                foreach (hist[i][k]) if (hist[i][k] == m_db[i]) all_diff = 1'b0;
                if (all_diff) ndb[i] = m_s2[i];
            end
            m_db = ndb;
            m_s2 = m_s1;
            m_s1 = SW;
        end
    endtask

    task automatic tick();
        @(posedge CLK100MHZ);
        model_step();
        @(negedge CLK100MHZ);
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        string      tag;
        logic       rst_n;
        logic [2:0] sw;
        logic [2:0] exp_sel;
        logic       exp_chg;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string tag, input logic r, input logic [2:0] sw,
                                input logic [2:0] es, input logic ec, input int n);
        vec_t v;
        v.tag = tag; v.rst_n = r; v.sw = sw; v.exp_sel = es; v.exp_chg = ec;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    initial begin
        // Reset with all switches on, then release: multi-hot stays off.
        add("rst_hold",   1'b0, 3'b111, 3'b000, 1'b0, 3);
        add("rst_rel111", 1'b1, 3'b111, 3'b000, 1'b0, 10);
        add("clr",        1'b0, 3'b000, 3'b000, 1'b0, 2);
        // 000 -> 001: new select exactly at edge 7 with a single strobe.
        add("r_wait",     1'b1, 3'b001, 3'b000, 1'b0, 6);
        add("r_edge7",    1'b1, 3'b001, 3'b001, 1'b1, 1);
        add("r_hold",     1'b1, 3'b001, 3'b001, 1'b0, 2);
        // 001 -> 011: multi-hot.
        add("mh_wait",    1'b1, 3'b011, 3'b001, 1'b0, 6);
`ifdef SW_SELECT_STICKY_EN
        add("mh_edge7",   1'b1, 3'b011, 3'b001, 1'b0, 1);
        add("mh_hold",    1'b1, 3'b011, 3'b001, 1'b0, 2);
`else
        add("mh_edge7",   1'b1, 3'b011, 3'b000, 1'b1, 1);
        add("mh_hold",    1'b1, 3'b011, 3'b000, 1'b0, 2);
`endif
        add("clr",        1'b0, 3'b000, 3'b000, 1'b0, 2);
        // Short 3-cycle glitch on SW[1] is rejected.
        add("glitch_hi",  1'b1, 3'b010, 3'b000, 1'b0, 3);
        add("glitch_lo",  1'b1, 3'b000, 3'b000, 1'b0, 10);
        add("clr",        1'b0, 3'b000, 3'b000, 1'b0, 2);
        // Reset mid-debounce loses the partial count.
        add("b_pre",      1'b1, 3'b100, 3'b000, 1'b0, 3);
        add("b_rst",      1'b0, 3'b100, 3'b000, 1'b0, 1);
        add("b_wait",     1'b1, 3'b100, 3'b000, 1'b0, 6);
        add("b_edge7",    1'b1, 3'b100, 3'b100, 1'b1, 1);
        add("b_hold",     1'b1, 3'b100, 3'b100, 1'b0, 2);
        add("clr",        1'b0, 3'b000, 3'b000, 1'b0, 2);
        // Bounce every 2 cycles, then settle.
        for (int p = 0; p < 5; p++) begin
            add("bounce_hi", 1'b1, 3'b100, 3'b000, 1'b0, 2);
            add("bounce_lo", 1'b1, 3'b000, 3'b000, 1'b0, 2);
        end
        add("settle_wait", 1'b1, 3'b100, 3'b000, 1'b0, 6);
        add("settle_edge7",1'b1, 3'b100, 3'b100, 1'b1, 1);
        add("settle_hold", 1'b1, 3'b100, 3'b100, 1'b0, 2);
        add("clr",         1'b0, 3'b000, 3'b000, 1'b0, 2);

        for (int j = 0; j < vecs.size(); j++) begin
            reset = vecs[j].rst_n;
            SW    = vecs[j].sw;
            tick();
            check({vecs[j].tag, "_sel"}, sel, vecs[j].exp_sel);
            check({vecs[j].tag, "_chg"}, {2'b00, changed}, {2'b00, vecs[j].exp_chg});
        end

        // Randomised switch activity with occasional reset.
        begin
            int hold = 0;
            for (int c = 0; c < 4000; c++) begin
                reset = ($urandom_range(0, 299) != 0);
                if (hold == 0) begin
                    SW   = 3'($urandom_range(0, 7));
                    hold = $urandom_range(1, 12);
                end else begin
                    hold--;
                end
                tick();
                check("rand_sel", sel, m_sel);
                check("rand_chg", {2'b00, changed}, {2'b00, m_chg});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
